// File: rtl/saw_envelope.sv
// saw_envelope: ADSR envelope / VCA stage for the sawtooth oscillator.
// Gate edges move the ADSR state machine. The envelope accumulator steps on
// enable ticks. The oscillator sample is scaled by the integer part of the
// envelope level.
module saw_envelope #(
  parameter int unsigned WAVE_BITS = 8,
  parameter int unsigned ENV_BITS  = 8,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned RATE_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 gate,
  input  logic [WAVE_BITS-1:0] wave_in,
  input  logic [RATE_BITS-1:0] attack_rate,
  input  logic [RATE_BITS-1:0] decay_rate,
  input  logic [ENV_BITS-1:0]  sustain_level,
  input  logic [RATE_BITS-1:0] release_rate,
  output logic [WAVE_BITS-1:0] wave_out,
  output logic [ENV_BITS-1:0]  env,
  output logic [2:0]           state
);

  localparam int unsigned ACC_BITS  = ENV_BITS + FRAC_BITS;
  localparam int unsigned PROD_BITS = WAVE_BITS + ENV_BITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_BITS-1:0]  acc_q, acc_d;
  logic                 gate_d;
  logic                 rise, fall, legal;
  logic [RATE_BITS-1:0] rate_sel;
  logic [ACC_BITS-1:0]  step, target;
  logic [ACC_BITS:0]    sum, limit;
  logic [PROD_BITS-1:0] prod;

  assign rise   = gate & ~gate_d;
  assign fall   = ~gate & gate_d;
  assign legal  = (state_q <= S_RELEASE);
  assign target = {sustain_level, {FRAC_BITS{1'b0}}};
  assign env    = acc_q[ACC_BITS-1 -: ENV_BITS];
  assign state  = state_q;
  assign prod   = PROD_BITS'(wave_in) * PROD_BITS'(env);

  // Register the state, the accumulator, the delayed gate and the scaled sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      gate_d   <= 1'b0;
      wave_out <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      gate_d   <= gate;
      wave_out <= prod[PROD_BITS-1 -: WAVE_BITS];
    end
  end

  // Select the step size for the current phase. The step is 1 << rate.
  always_comb begin
    rate_sel = '0;
    case (state_q)
      S_ATTACK:  rate_sel = attack_rate;
      S_DECAY:   rate_sel = decay_rate;
      S_RELEASE: rate_sel = release_rate;
      default:   rate_sel = '0;
    endcase
    step  = ACC_BITS'(1) << rate_sel;
    sum   = {1'b0, acc_q} + {1'b0, step};
    limit = {1'b0, target} + {1'b0, step};
  end

  // Compute the next state and level. Gate edges take priority over stepping,
  // so a retrigger or a note-off keeps the current level for that cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (!legal) begin
      state_d = S_IDLE;
      acc_d   = '0;
    end else if (rise) begin
      state_d = S_ATTACK;
    end else if (fall) begin
      if (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN)
        state_d = S_RELEASE;
    end else if (enable) begin
      case (state_q)
        S_IDLE: acc_d = '0;
        S_ATTACK: begin
          if (sum[ACC_BITS]) begin
            acc_d   = '1;
            state_d = S_DECAY;
          end else begin
            acc_d = sum[ACC_BITS-1:0];
          end
        end
        S_DECAY: begin
          if ({1'b0, acc_q} <= limit) begin
            acc_d   = target;
            state_d = S_SUSTAIN;
          end else begin
            acc_d = acc_q - step;
          end
        end
        S_SUSTAIN: acc_d = target;
        S_RELEASE: begin
          if (acc_q <= step) begin
            acc_d   = '0;
            state_d = S_IDLE;
          end else begin
            acc_d = acc_q - step;
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saw_envelope.sv
// tb_saw_envelope: directed and randomized checks of saw_envelope against an
// integer ADSR reference model.
module tb_saw_envelope;

  logic       clk = 1'b0;
  logic       reset, enable, gate;
  logic [7:0] wave_in, sustain_level;
  logic [3:0] attack_rate, decay_rate, release_rate;
  logic [7:0] wave_out, env;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model state: phase number, 16-bit level, delayed gate, sample.
  int m_st, m_acc, m_gd, m_wo;

  saw_envelope #(
    .WAVE_BITS(8),
    .ENV_BITS(8),
    .FRAC_BITS(8),
    .RATE_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .gate(gate),
    .wave_in(wave_in),
    .attack_rate(attack_rate),
    .decay_rate(decay_rate),
    .sustain_level(sustain_level),
    .release_rate(release_rate),
    .wave_out(wave_out),
    .env(env),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock, using the inputs presently applied.
  task automatic model_step();
    int rise, fall, step, tgt;
    if (reset) begin
      m_st = 0; m_acc = 0; m_gd = 0; m_wo = 0;
      return;
    end
    m_wo = (int'(wave_in) * (m_acc / 256)) / 256;
    rise = (gate && !m_gd) ? 1 : 0;
    fall = (!gate && m_gd) ? 1 : 0;
    tgt  = int'(sustain_level) * 256;
    if (rise != 0) begin
      m_st = 1;
    end else if (fall != 0) begin
      if (m_st >= 1 && m_st <= 3) m_st = 4;
    end else if (enable) begin
      case (m_st)
        0: m_acc = 0;
        1: begin
          step = 1 << attack_rate;
          if (m_acc + step >= 65536) begin m_acc = 65535; m_st = 2; end
          else m_acc = m_acc + step;
        end
        2: begin
          step = 1 << decay_rate;
          if (m_acc <= tgt + step) begin m_acc = tgt; m_st = 3; end
          else m_acc = m_acc - step;
        end
        3: m_acc = tgt;
        default: begin
          step = 1 << release_rate;
          if (m_acc <= step) begin m_acc = 0; m_st = 0; end
          else m_acc = m_acc - step;
        end
      endcase
    end
    m_gd = gate ? 1 : 0;
  endtask

  // One clock: update the model, let the edge pass, then compare all outputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_val("state", int'(state), m_st);
    check_val("env", int'(env), m_acc / 256);
    check_val("wave_out", int'(wave_out), m_wo);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; gate = 1'b1; wave_in = 8'hFF;
    attack_rate = 4'd15; decay_rate = 4'd14; release_rate = 4'd15;
    sustain_level = 8'h80;
    m_st = 0; m_acc = 0; m_gd = 0; m_wo = 0;
    repeat (3) cycle();
    check_val("reset_state", int'(state), 0);
    check_val("reset_env", int'(env), 0);
    check_val("reset_wave", int'(wave_out), 0);

    // A gate held high through reset appears as a rise on the first clock.
    reset = 1'b0;
    cycle();
    check_val("rise_after_reset", int'(state), 1);
    check_val("rise_acc0", int'(env), 8'h00);
    cycle();
    check_val("attack_tick1", int'(env), 8'h80);
    cycle();
    check_val("attack_top_state", int'(state), 2);
    check_val("attack_top_env", int'(env), 8'hFF);
    wave_in = 8'h80;
    cycle();
    check_val("vca_full_scale", int'(wave_out), 8'h7F);
    check_val("decay_tick1", int'(env), 8'hBF);
    cycle();
    check_val("decay_land_state", int'(state), 3);
    check_val("decay_land_env", int'(env), 8'h80);
    sustain_level = 8'h40;
    cycle();
    check_val("sustain_track", int'(env), 8'h40);
    sustain_level = 8'h80;
    cycle();

    // Note-off keeps the level for the cycle of the edge.
    gate = 1'b0;
    cycle();
    check_val("release_entry_state", int'(state), 4);
    check_val("release_entry_env", int'(env), 8'h80);
    cycle();
    check_val("release_done_state", int'(state), 0);
    check_val("release_done_env", int'(env), 0);
    cycle();
    check_val("release_done_wave", int'(wave_out), 0);

    // Attack to 0x3000, release, then retrigger while enable is high.
    attack_rate = 4'd12;
    gate = 1'b1;
    repeat (4) cycle();
    check_val("attack_0x3000", int'(env), 8'h30);
    gate = 1'b0;
    cycle();
    gate = 1'b1;
    cycle();
    check_val("retrigger_state", int'(state), 1);
    check_val("retrigger_env", int'(env), 8'h30);
    cycle();
    check_val("retrigger_step", int'(env), 8'h40);

    // With enable held low, the level freezes while the VCA keeps tracking wave_in.
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wave_in = 8'($urandom);
      cycle();
    end
    check_val("hold_state", int'(state), 1);
    check_val("hold_env", int'(env), 8'h40);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) gate = ~gate;
      wave_in       = 8'($urandom);
      attack_rate   = 4'($urandom_range(6, 15));
      decay_rate    = 4'($urandom_range(6, 15));
      release_rate  = 4'($urandom_range(6, 15));
      if ($urandom_range(0, 31) == 0) sustain_level = 8'($urandom);
      if ($urandom_range(0, 63) == 0) sustain_level = 8'hFF;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/saw_envelope.md
Name: saw_envelope

Overview:
ADSR envelope/VCA stage directly downstream of the sawtooth oscillator. Takes the unsigned oscillator sample and a gate, runs an attack/decay/sustain/release state machine on an envelope accumulator stepped on divider enable ticks, and outputs the sample scaled by the envelope level. Its output drives uo_out in place of the raw wave.

Parameters:
WAVE_BITS, 8, width of oscillator sample in/out (unsigned)
ENV_BITS, 8, integer width of envelope level
FRAC_BITS, 8, fractional bits of envelope accumulator; ACC_BITS = ENV_BITS+FRAC_BITS
RATE_BITS, 4, width of rate fields; step = 1 << rate; requires 2^RATE_BITS-1 < ACC_BITS

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  envelope step tick (one octave-divider enable bit, ANDed with ena upstream)
gate  input  1  note on (1) / off (0), level-sensitive
wave_in  input  WAVE_BITS  unsigned oscillator sample
attack_rate  input  RATE_BITS  attack step exponent
decay_rate  input  RATE_BITS  decay step exponent
sustain_level  input  ENV_BITS  sustain level; target = {sustain_level, FRAC_BITS'b0}
release_rate  input  RATE_BITS  release step exponent
wave_out  output  WAVE_BITS  scaled sample, registered
env  output  ENV_BITS  acc[ACC_BITS-1 -: ENV_BITS], combinational from acc
state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4

Behaviour:
- One clock; reset synchronous active-high. Reset: state=IDLE, acc=0, gate_d=0, wave_out=0, so env=0.
- gate_d registers gate every clk (not gated by enable). rise = gate & ~gate_d; fall = ~gate & gate_d.
- Gate events, every cycle, priority over stepping (acc not stepped that cycle even if enable=1):
  - rise in any state -> ATTACK; acc kept (retrigger from current level, no click).
  - fall in ATTACK/DECAY/SUSTAIN -> RELEASE; acc kept. fall in IDLE/RELEASE: ignored.
- Stepping only when enable=1 and no gate event; step = 1 << rate, ACC_BITS wide:
  - IDLE: acc held at 0.
  - ATTACK: sum = acc + step computed ACC_BITS+1 wide; if sum >= 2^ACC_BITS: acc = all ones, -> DECAY; else acc = sum.
  - DECAY: if acc <= target + step (compare without wrap): acc = target, -> SUSTAIN; else acc -= step. With sustain all ones, lands in SUSTAIN on first tick at target.
  - SUSTAIN: acc = target every tick (tracks live sustain_level changes); stays until fall.
  - RELEASE: if acc <= step: acc = 0, -> IDLE; else acc -= step.
- Illegal state encodings (5..7) -> IDLE, acc = 0, on next clk.
- Level-held gate with no edge never re-enters ATTACK; gate high out of reset is seen as a rise on the first clk after reset deasserts.
- wave_out <= (wave_in * env) >> ENV_BITS, full-width unsigned product, truncated; updated every clk regardless of enable; latency 1 cycle from wave_in/env. env=all ones gives wave_in - (wave_in>0 ? 1 : 0) for 8/8 (x*255>>8); env=0 gives 0.
- Rates, sustain_level and wave_in may change any cycle; they take effect on the next step/product.
- Reset mid-note: all state cleared next clk; wave_out 0 the cycle after reset is seen.

Test Plan:
- Reset with gate=1, wave_in=0xFF -> state=IDLE, env=0, wave_out=0 while reset=1; first clk after release -> ATTACK, acc=0.
- attack_rate=15, enable=1 constant, gate rise -> acc 0x8000 after 1st tick, 0xFFFF after 2nd with state=DECAY; wave_in=0x80 -> wave_out=0x7F one cycle later.
- From DECAY at 0xFFFF, decay_rate=14, sustain=0x80 -> 0xBFFF, then 0x8000 and SUSTAIN; change sustain to 0x40 -> acc=0x4000 next tick.
- gate fall in SUSTAIN at acc=0x8000, release_rate=15 -> RELEASE, no step that cycle; next tick acc=0, state=IDLE, env=0, wave_out=0 a cycle later.
- gate rise and enable in same cycle while in RELEASE at acc=0x3000 -> ATTACK, acc stays 0x3000; with attack_rate=12, next tick acc=0x4000.
- enable=0 for 100 cycles with gate=1 in ATTACK -> acc and state unchanged; wave_out still tracks wave_in*env with 1-cycle latency.
